// File: rtl/fwd_hazard_pipe.sv
// Forwarding and load-use hazard control for the in-order pipeline.
// Tracks destination registers of in-flight instructions and emits forward selects, stall and writeback control.
module fwd_hazard_pipe #(
    parameter int RN_W     = 5,
    parameter int FW_DEPTH = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [RN_W-1:0]  rs_n_i,
    input  logic [RN_W-1:0]  rt_n_i,
    input  logic             rs_used_i,
    input  logic             rt_used_i,
    input  logic [RN_W-1:0]  rd_n_i,
    input  logic             we_i,
    input  logic             ld_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [SEL_W-1:0] rs_fw_sel_o,
    output logic [SEL_W-1:0] rt_fw_sel_o,
    output logic             wb_we_o,
    output logic [RN_W-1:0]  wb_rn_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [FW_DEPTH-1:0] v_q;
    logic [FW_DEPTH-1:0] we_q;
    logic [FW_DEPTH-1:0] ld_q;
    logic [RN_W-1:0]     rn_q [FW_DEPTH];
    logic [CNT_W-1:0]    cnt_q;

    logic [FW_DEPTH-1:0] writer;
    logic [SEL_W-1:0]    rs_sel;
    logic [SEL_W-1:0]    rt_sel;
    logic                rs_hazard;
    logic                rt_hazard;
    logic                stall;

    always_comb begin
        for (int k = 0; k < FW_DEPTH; k++) begin
            writer[k] = v_q[k] & we_q[k] & (rn_q[k] != '0);
        end
    end

    // Scan oldest to youngest so the youngest matching stage overwrites last.
    always_comb begin
        rs_sel    = '0;
        rt_sel    = '0;
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        for (int k = FW_DEPTH - 1; k >= 0; k--) begin
            if (rs_used_i && writer[k] && (rn_q[k] == rs_n_i)) begin
                rs_sel    = SEL_W'(k + 1);
                rs_hazard = ld_q[k] && (k < LOAD_LAT);
            end
            if (rt_used_i && writer[k] && (rn_q[k] == rt_n_i)) begin
                rt_sel    = SEL_W'(k + 1);
                rt_hazard = ld_q[k] && (k < LOAD_LAT);
            end
        end
    end

    assign stall       = id_valid_i & (rs_hazard | rt_hazard) & ~flush_i;
    assign stall_o     = stall;
    assign rs_fw_sel_o = stall ? '0 : rs_sel;
    assign rt_fw_sel_o = stall ? '0 : rt_sel;
    assign wb_we_o     = writer[FW_DEPTH-1];
    assign wb_rn_o     = writer[FW_DEPTH-1] ? rn_q[FW_DEPTH-1] : '0;
    assign stall_cnt_o = cnt_q;

    // Older stages always advance; a stalled or flushed decode enters as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            we_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < FW_DEPTH; k++) begin
                rn_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < FW_DEPTH; k++) begin
                v_q[k]  <= v_q[k-1];
                we_q[k] <= we_q[k-1];
                ld_q[k] <= ld_q[k-1];
                rn_q[k] <= rn_q[k-1];
            end
            v_q[0]  <= id_valid_i & ~flush_i & ~stall;
            we_q[0] <= we_i;
            ld_q[0] <= ld_i;
            rn_q[0] <= rd_n_i;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_pipe.sv
// Directed, table-driven bench for fwd_hazard_pipe with a second 4-bit-counter instance sharing the inputs.
module tb_fwd_hazard_pipe;

    typedef struct {
        logic        vld;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rsu;
        logic        rtu;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        fl;
        logic        e_stall;
        logic [1:0]  e_rs_sel;
        logic [1:0]  e_rt_sel;
        logic        e_wb_we;
        logic [4:0]  e_wb_rn;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs_n;
    logic [4:0]  rt_n;
    logic        rs_used;
    logic        rt_used;
    logic [4:0]  rd_n;
    logic        we;
    logic        ld;
    logic        flush;

    logic        stall;
    logic [1:0]  rs_sel;
    logic [1:0]  rt_sel;
    logic        wb_we;
    logic [4:0]  wb_rn;
    logic [15:0] cnt;

    logic        stall4;
    logic [1:0]  rs_sel4;
    logic [1:0]  rt_sel4;
    logic        wb_we4;
    logic [4:0]  wb_rn4;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;

    fwd_hazard_pipe dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .rs_n_i(rs_n), .rt_n_i(rt_n),
        .rs_used_i(rs_used), .rt_used_i(rt_used), .rd_n_i(rd_n), .we_i(we), .ld_i(ld),
        .flush_i(flush), .stall_o(stall), .rs_fw_sel_o(rs_sel), .rt_fw_sel_o(rt_sel),
        .wb_we_o(wb_we), .wb_rn_o(wb_rn), .stall_cnt_o(cnt)
    );

    fwd_hazard_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .rs_n_i(rs_n), .rt_n_i(rt_n),
        .rs_used_i(rs_used), .rt_used_i(rt_used), .rd_n_i(rd_n), .we_i(we), .ld_i(ld),
        .flush_i(flush), .stall_o(stall4), .rs_fw_sel_o(rs_sel4), .rt_fw_sel_o(rt_sel4),
        .wb_we_o(wb_we4), .wb_rn_o(wb_rn4), .stall_cnt_o(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int vld, input int rs, input int rt, input int rsu,
                                input int rtu, input int rd, input int w, input int l,
                                input int fl, input int es, input int ers, input int ert,
                                input int ewe, input int ern, input int ecnt);
        vec_t v;
        v.vld = 1'(vld);  v.rs = 5'(rs);   v.rt = 5'(rt);   v.rsu = 1'(rsu);
        v.rtu = 1'(rtu);  v.rd = 5'(rd);   v.we = 1'(w);    v.ld = 1'(l);
        v.fl = 1'(fl);    v.e_stall = 1'(es);
        v.e_rs_sel = 2'(ers);  v.e_rt_sel = 2'(ert);
        v.e_wb_we = 1'(ewe);   v.e_wb_rn = 5'(ern);  v.e_cnt = 16'(ecnt);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        id_valid = v.vld;  rs_n = v.rs;  rt_n = v.rt;  rs_used = v.rsu;  rt_used = v.rtu;
        rd_n = v.rd;  we = v.we;  ld = v.ld;  flush = v.fl;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [15:0] act,
                               input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        checkOutput("stall",    idx, 16'(stall),   16'(v.e_stall));
        checkOutput("rs_sel",   idx, 16'(rs_sel),  16'(v.e_rs_sel));
        checkOutput("rt_sel",   idx, 16'(rt_sel),  16'(v.e_rt_sel));
        checkOutput("wb_we",    idx, 16'(wb_we),   16'(v.e_wb_we));
        checkOutput("wb_rn",    idx, 16'(wb_rn),   16'(v.e_wb_rn));
        checkOutput("cnt",      idx, cnt,          v.e_cnt);
        checkOutput("stall4",   idx, 16'(stall4),  16'(v.e_stall));
        checkOutput("rs_sel4",  idx, 16'(rs_sel4), 16'(v.e_rs_sel));
        checkOutput("rt_sel4",  idx, 16'(rt_sel4), 16'(v.e_rt_sel));
        checkOutput("wb_we4",   idx, 16'(wb_we4),  16'(v.e_wb_we));
        checkOutput("wb_rn4",   idx, 16'(wb_rn4),  16'(v.e_wb_rn));
        checkOutput("cnt4",     idx, 16'(cnt4),    v.e_cnt);
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[17];
    vec_t idle;

    initial begin
        // vld rs rt rsu rtu rd we ld fl | stall rs_sel rt_sel wb_we wb_rn cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 3, 0, 1, 3, 0);
        vecs[4]  = mk(1, 3, 3, 1, 1, 5, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 5, 0, 1, 6, 1, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 5, 0, 1, 6, 1, 0, 0,  0, 0, 2, 0, 0, 1);
        vecs[7]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 5, 1);
        vecs[8]  = mk(1, 0, 6, 1, 1, 7, 1, 0, 0,  0, 0, 2, 0, 0, 1);
        vecs[9]  = mk(1, 6, 7, 1, 0, 9, 1, 0, 0,  0, 3, 0, 1, 6, 1);
        vecs[10] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[11] = mk(1, 9, 9, 1, 1, 5, 1, 1, 0,  0, 1, 1, 1, 7, 1);
        vecs[12] = mk(1, 0, 5, 0, 1, 8, 1, 0, 1,  0, 0, 1, 1, 9, 1);
        vecs[13] = mk(0, 8, 5, 1, 1, 10, 1, 0, 0, 0, 0, 2, 1, 9, 1);
        vecs[14] = mk(1, 10, 0, 1, 0, 11, 1, 1, 0, 0, 0, 0, 1, 5, 1);
        vecs[15] = mk(0, 11, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[16] = mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        id_valid = 1'b0;  rs_n = '0;  rt_n = '0;  rs_used = 1'b0;  rt_used = 1'b0;
        rd_n = '0;  we = 1'b0;  ld = 1'b0;  flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(idle);
        checkVector(idle, -1);
        stepClock();

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i], i);
            stepClock();
        end

        // Twenty separate load-use stalls: wide counter reaches 21, narrow one pins at 15.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
            stepClock();
            applyStimulus(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            checkOutput("sat_stall", 100 + i, 16'(stall), 16'd1);
            stepClock();
            applyStimulus(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            checkOutput("sat_release", 100 + i, 16'(stall), 16'd0);
            checkOutput("sat_rt_sel", 100 + i, 16'(rt_sel), 16'd2);
            stepClock();
        end
        applyStimulus(idle);
        checkOutput("cnt_wide", 200, cnt, 16'd21);
        checkOutput("cnt_sat4", 200, 16'(cnt4), 16'd15);
        stepClock();

        // Fill the pipeline, then reset while a load-use stall is pending.
        applyStimulus(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        stepClock();
        applyStimulus(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        stepClock();
        applyStimulus(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        stepClock();
        applyStimulus(mk(1, 3, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("pre_rst_stall", 300, 16'(stall), 16'd1);
        checkOutput("pre_rst_wb_we", 300, 16'(wb_we), 16'd1);
        checkOutput("pre_rst_wb_rn", 300, 16'(wb_rn), 16'd1);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_stall",  301, 16'(stall),  16'd0);
        checkOutput("rst_rs_sel", 301, 16'(rs_sel), 16'd0);
        checkOutput("rst_rt_sel", 301, 16'(rt_sel), 16'd0);
        checkOutput("rst_wb_we",  301, 16'(wb_we),  16'd0);
        checkOutput("rst_wb_rn",  301, 16'(wb_rn),  16'd0);
        checkOutput("rst_cnt",    301, cnt,         16'd0);
        checkOutput("rst_cnt4",   301, 16'(cnt4),   16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
